conv_sa_sum_drain: RTL and testbench

Collects the final 32-bit sums leaving one row of sum units in the convolution systolic array and delivers them as aligned vectors. The row produces lane i's sums i cycles after lane 0, so this block de-skews the P lanes and buffers complete vectors in a FIFO. It then streams each vector to the output-write path as two valid/ready beats: sum1 first, then sum2. It sits between the sum-row outputs and the convolution result writer, and raises almost-full so the convolution controller can stop issuing final rounds.

---
 rtl/conv_sa_pkg.sv | 17 +
 rtl/conv_sa_sum_drain_if.sv | 27 ++
 rtl/conv_sa_sum_fifo.sv | 58 +++++
 rtl/conv_sa_sum_drain.sv | 135 +++++++++++++
 tb/tb_conv_sa_sum_drain.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_sa_pkg.sv
// Shared definitions for the convolution systolic-array sum drain path:
// sum width, drain entry layout and serializer state encoding.
package conv_sa_pkg;

  localparam int SUM_W = 32;

  // Drain entry layout is {sum2, sum1}: sum1 lanes in the low half, sum2 lanes above.
  function automatic int entry_w(input int lanes);
    return 2 * lanes * SUM_W;
  endfunction

  typedef enum logic {
    S_SUM1 = 1'b0,
    S_SUM2 = 1'b1
  } drain_state_e;

endpackage

// File: rtl/conv_sa_sum_drain_if.sv
// Sum-row input bus and two-beat result stream of the sum drain block.
interface conv_sa_sum_drain_if #(
  parameter int P = 4
);
  import conv_sa_pkg::*;

  logic [P*SUM_W-1:0] in_sum1;
  logic [P*SUM_W-1:0] in_sum2;
  logic               in_vld;
  logic [P*SUM_W-1:0] out_data;
  logic               out_vld;
  logic               out_rdy;
  logic               out_last;
  logic               almost_full;
  logic               overflow;

  modport master (
    output in_sum1, in_sum2, in_vld, out_rdy,
    input  out_data, out_vld, out_last, almost_full, overflow
  );

  modport slave (
    input  in_sum1, in_sum2, in_vld, out_rdy,
    output out_data, out_vld, out_last, almost_full, overflow
  );

endinterface

// File: rtl/conv_sa_sum_fifo.sv
// Synchronous FIFO for aligned sum vectors; storage has no reset so it maps
// onto distributed RAM with a combinational head read.
module conv_sa_sum_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_sa_sum_drain.sv
// De-skews one sum row's P lanes, buffers aligned {sum2, sum1} vectors and
// streams each one out as two valid/ready beats (sum1, then sum2).
module conv_sa_sum_drain
  import conv_sa_pkg::*;
#(
  parameter int P         = 4,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 4
) (
  input logic               clk,
  input logic               rst,
  conv_sa_sum_drain_if.slave bus
);

  localparam int LANE_W  = P * SUM_W;
  localparam int ENTRY_W = entry_w(P);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [P-1:0][SUM_W-1:0] al_sum1;
  logic [P-1:0][SUM_W-1:0] al_sum2;
  logic [P-2:0]            vld_p;
  logic                    wr_vld;

  logic [ENTRY_W-1:0]      head;
  logic                    full;
  logic                    empty;
  logic [CNT_W-1:0]        count;
  logic                    pop;

  drain_state_e            state_q;
  drain_state_e            state_d;
  logic                    out_vld_c;
  logic                    out_last_c;
  logic [LANE_W-1:0]       out_data_c;
  logic                    af_q;
  logic                    ovf_q;

  // De-skew stage: lane i waits P-1-i cycles so every lane lines up with lane P-1
  for (genvar i = 0; i < P; i++) begin : g_lane
    localparam int D = P - 1 - i;
    if (D == 0) begin : g_direct
      assign al_sum1[i] = bus.in_sum1[i*SUM_W +: SUM_W];
      assign al_sum2[i] = bus.in_sum2[i*SUM_W +: SUM_W];
    end else begin : g_delay
      logic [SUM_W-1:0] dsk1_p [D];
      logic [SUM_W-1:0] dsk2_p [D];
      always_ff @(posedge clk) begin
        dsk1_p[0] <= bus.in_sum1[i*SUM_W +: SUM_W];
        dsk2_p[0] <= bus.in_sum2[i*SUM_W +: SUM_W];
        for (int k = 1; k < D; k++) begin
          dsk1_p[k] <= dsk1_p[k-1];
          dsk2_p[k] <= dsk2_p[k-1];
        end
      end
      assign al_sum1[i] = dsk1_p[D-1];
      assign al_sum2[i] = dsk2_p[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= bus.in_vld;
      for (int k = 1; k < P - 1; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  assign wr_vld = vld_p[P-2];

  // Buffer stage: aligned vectors queue up for the serializer
  conv_sa_sum_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_vld),
    .din   ({al_sum2, al_sum1}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Serializer stage: outputs come straight from the FIFO head, so they hold until popped
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_SUM1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    out_vld_c  = 1'b0;
    out_last_c = 1'b0;
    out_data_c = head[LANE_W-1:0];
    case (state_q)
      S_SUM1: begin
        out_vld_c = !empty;
        if (!empty && bus.out_rdy) state_d = S_SUM2;
      end
      S_SUM2: begin
        out_vld_c  = 1'b1;
        out_last_c = 1'b1;
        out_data_c = head[ENTRY_W-1:LANE_W];
        if (bus.out_rdy) begin
          pop     = 1'b1;
          state_d = S_SUM1;
        end
      end
      default: state_d = S_SUM1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      af_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      af_q <= ((DEPTH - int'(count)) <= AF_MARGIN);
      if (wr_vld && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign bus.out_vld     = out_vld_c;
  assign bus.out_last    = out_last_c;
  assign bus.out_data    = out_data_c;
  assign bus.almost_full = af_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_conv_sa_sum_drain.sv
// Bench for conv_sa_sum_drain: skewed lane driver, beat scoreboard, table of
// single-vector cases and hand sequences for backpressure, fill and reset.
module tb_conv_sa_sum_drain;
  import conv_sa_pkg::*;

  localparam int P         = 4;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 4;
  localparam int LW        = P * SUM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sa_sum_drain_if #(.P(P)) bus ();

  conv_sa_sum_drain #(
    .P         (P),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [LW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [LW-1:0] s1;
    logic [LW-1:0] s2;
    logic [LW-1:0] exp0;
    logic [LW-1:0] exp1;
  } vec_rec_t;

  beat_t         sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            beats   = 0;
  logic [LW-1:0] hs1 [P];
  logic [LW-1:0] hs2 [P];
  bit            hv  [P];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Lane i carries the vector started i cycles ago; idle lanes carry junk.
  task automatic step(input bit v, input bit acc, input logic [LW-1:0] s1, input logic [LW-1:0] s2);
    for (int k = P - 1; k > 0; k--) begin
      hs1[k] = hs1[k-1];
      hs2[k] = hs2[k-1];
      hv[k]  = hv[k-1];
    end
    hs1[0] = s1;
    hs2[0] = s2;
    hv[0]  = v;
    bus.in_vld = v;
    for (int i = 0; i < P; i++) begin
      bus.in_sum1[i*SUM_W +: SUM_W] = hv[i] ? hs1[i][i*SUM_W +: SUM_W] : SUM_W'($urandom);
      bus.in_sum2[i*SUM_W +: SUM_W] = hv[i] ? hs2[i][i*SUM_W +: SUM_W] : SUM_W'($urandom);
    end
    if (v && acc) begin
      sb.push_back('{s1, 1'b0});
      sb.push_back('{s2, 1'b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [LW-1:0] mkvec(input logic [31:0] base);
    logic [LW-1:0] v;
    for (int i = 0; i < P; i++) v[i*SUM_W +: SUM_W] = base + 32'(i);
    return v;
  endfunction

  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst && bus.out_vld && bus.out_rdy) begin
      beats++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got beat %h last %b, required no beat", bus.out_data, bus.out_last);
      end else begin
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_last", LW'(bus.out_last), LW'(e.last));
      end
    end
  end

  initial begin
    vec_rec_t    tbl [4];
    logic [11:0] pat;
    bit          bp_ok;
    int          b0;

    tbl[0] = '{{32'h103, 32'h102, 32'h101, 32'h100}, {32'h203, 32'h202, 32'h201, 32'h200},
               {32'h103, 32'h102, 32'h101, 32'h100}, {32'h203, 32'h202, 32'h201, 32'h200}};
    tbl[1] = '{{4{32'hFFFF_FFFF}}, {4{32'h0}}, {4{32'hFFFF_FFFF}}, {4{32'h0}}};
    tbl[2] = '{{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h5A5A_5A5A},
               {32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
               {32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h5A5A_5A5A},
               {32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0}};
    tbl[3] = '{{32'h8000_0003, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
               {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0},
               {32'h8000_0003, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
               {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0}};

    for (int k = 0; k < P; k++) begin
      hv[k]  = 1'b0;
      hs1[k] = '0;
      hs2[k] = '0;
    end
    bus.in_vld  = 1'b0;
    bus.in_sum1 = '0;
    bus.in_sum2 = '0;
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_vld", LW'(bus.out_vld), '0);
    chk("rst_out_last", LW'(bus.out_last), '0);
    chk("rst_almost_full", LW'(bus.almost_full), '0);
    chk("rst_overflow", LW'(bus.overflow), '0);

    // Single vectors: latency P cycles, then two back-to-back beats
    for (int r = 0; r < 4; r++) begin
      bus.out_rdy = 1'b1;
      step(1'b1, 1'b1, tbl[r].s1, tbl[r].s2);
      idle(2);
      chk("single_not_early", LW'(bus.out_vld), '0);
      idle(1);
      chk("single_b0_vld", LW'(bus.out_vld), LW'(1));
      chk("single_b0_data", bus.out_data, tbl[r].exp0);
      chk("single_b0_last", LW'(bus.out_last), '0);
      idle(1);
      chk("single_b1_vld", LW'(bus.out_vld), LW'(1));
      chk("single_b1_data", bus.out_data, tbl[r].exp1);
      chk("single_b1_last", LW'(bus.out_last), LW'(1));
      idle(1);
      chk("single_done", LW'(bus.out_vld), '0);
      idle(2);
    end

    // Back-to-back inputs give six gapless beats
    bus.out_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b1, mkvec(32'h1000 + 32'(j * 16)), mkvec(32'h2000 + 32'(j * 16)));
    end
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      pat[k] = bus.out_vld;
      idle(1);
    end
    chk("b2b_vld_pattern", LW'(pat), LW'(12'h07E));

    // Backpressure: beat 0 holds for 20 cycles
    bus.out_rdy = 1'b0;
    step(1'b1, 1'b1, mkvec(32'h3000), mkvec(32'h4000));
    idle(3);
    bp_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!(bus.out_vld === 1'b1 && bus.out_data === mkvec(32'h3000) && bus.out_last === 1'b0))
        bp_ok = 1'b0;
      idle(1);
    end
    chk("bp_hold", LW'(bp_ok), LW'(1));
    bus.out_rdy = 1'b1;
    idle(1);
    chk("bp_b1_last", LW'(bus.out_last), LW'(1));
    chk("bp_b1_data", bus.out_data, mkvec(32'h4000));
    idle(1);
    chk("bp_done", LW'(bus.out_vld), '0);

    // Fill to full, ninth vector dropped, overflow sticks
    b0 = beats;
    bus.out_rdy = 1'b0;
    for (int j = 0; j < 9; j++) begin
      step(1'b1, j < 8, mkvec(32'h5000 + 32'(j * 16)), mkvec(32'h6000 + 32'(j * 16)));
      if (j == 6) chk("fill_af_before", LW'(bus.almost_full), '0);
      if (j == 7) chk("fill_af_after", LW'(bus.almost_full), LW'(1));
    end
    idle(2);
    chk("fill_ovf_before", LW'(bus.overflow), '0);
    idle(1);
    chk("fill_ovf_set", LW'(bus.overflow), LW'(1));
    idle(5);
    chk("fill_ovf_sticky", LW'(bus.overflow), LW'(1));
    bus.out_rdy = 1'b1;
    idle(20);
    chk("fill_drain_beats", LW'(beats - b0), LW'(16));
    chk("fill_sb_empty", LW'(sb.size()), '0);
    chk("fill_ovf_after_drain", LW'(bus.overflow), LW'(1));
    chk("fill_af_after_drain", LW'(bus.almost_full), '0);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    sb.delete();
    chk("ovf_cleared_by_rst", LW'(bus.overflow), '0);

    // Push coinciding with beat-1 handshake at full is accepted
    b0 = beats;
    for (int j = 0; j < 14; j++) begin
      bus.out_rdy = (j == 10 || j == 11);
      step(j < 9, 1'b1, mkvec(32'h7000 + 32'(j * 16)), mkvec(32'h8000 + 32'(j * 16)));
    end
    chk("full_pp_ovf", LW'(bus.overflow), '0);
    chk("full_pp_af", LW'(bus.almost_full), LW'(1));
    chk("full_pp_beats", LW'(beats - b0), LW'(2));
    bus.out_rdy = 1'b1;
    idle(20);
    chk("full_pp_drain_beats", LW'(beats - b0), LW'(18));
    chk("full_pp_sb_empty", LW'(sb.size()), '0);

    // Reset with three vectors buffered and two still de-skewing
    b0 = beats;
    bus.out_rdy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b1, mkvec(32'h9000 + 32'(j * 16)), mkvec(32'hA000 + 32'(j * 16)));
    end
    idle(1);
    chk("mid_vld_before_rst", LW'(bus.out_vld), LW'(1));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_out_vld", LW'(bus.out_vld), '0);
    chk("mid_rst_af", LW'(bus.almost_full), '0);
    chk("mid_rst_ovf", LW'(bus.overflow), '0);
    bus.out_rdy = 1'b1;
    idle(15);
    chk("mid_rst_no_beats", LW'(beats - b0), '0);
    chk("mid_rst_idle", LW'(bus.out_vld), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
